// File: rtl/lsu_16b.sv
// Load/store unit: one or two little-endian byte cycles on an 8-bit bus per request.
// Optional feature macro: LSU_PAGE_WRAP_EN (second byte wraps within the 256-byte page).
module lsu_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lsu_adr,
  input  logic [15:0] lsu_payload,
  input  logic        sched_start,
  input  logic        sched_we,
  input  logic        sched_wide,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [15:0] rf_ld,
  output logic        rf_ld_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_rdy
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] adr_q, pay_q, data_q;
  logic        we_q, wide_q, done_q;
  logic [15:0] mem_adr_reg;
  logic [7:0]  mem_dout_reg;
  logic        mem_req_reg, mem_we_reg;
  logic        accept, fin;
  logic [15:0] adr_b1;

`ifdef LSU_PAGE_WRAP_EN
  assign adr_b1 = {adr_q[15:8], adr_q[7:0] + 8'd1};
`else
  assign adr_b1 = adr_q + 16'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    fin        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sched_start) begin
          accept     = 1'b1;
          state_next = BYTE0;
        end
      end
      BYTE0: begin
        if (mem_rdy) begin
          if (wide_q) begin
            state_next = BYTE1;
          end else begin
            state_next = IDLE;
            fin        = 1'b1;
          end
        end
      end
      BYTE1: begin
        if (mem_rdy) begin
          state_next = IDLE;
          fin        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q        <= 16'h0000;
      pay_q        <= 16'h0000;
      data_q       <= 16'h0000;
      we_q         <= 1'b0;
      wide_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_adr_reg  <= 16'h0000;
      mem_dout_reg <= 8'h00;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
    end else begin
      done_q      <= fin;
      mem_req_reg <= (state_next != IDLE);
      mem_we_reg  <= (state_next != IDLE) & (accept ? sched_we : we_q);
      if (accept) begin
        adr_q        <= lsu_adr;
        pay_q        <= lsu_payload;
        we_q         <= sched_we;
        wide_q       <= sched_wide;
        data_q       <= 16'h0000;
        mem_adr_reg  <= lsu_adr;
        mem_dout_reg <= lsu_payload[7:0];
      end
      if (state_reg == BYTE0 && mem_rdy) begin
        if (!we_q) data_q[7:0] <= mem_din;
        if (wide_q) begin
          mem_adr_reg  <= adr_b1;
          mem_dout_reg <= pay_q[15:8];
        end
      end
      if (state_reg == BYTE1 && mem_rdy && !we_q) begin
        data_q[15:8] <= mem_din;
      end
    end
  end

  assign lsu_busy = (state_reg != IDLE);
  assign lsu_done = done_q;
  assign rf_ld    = data_q;
  assign rf_ld_we = done_q & ~we_q;
  assign mem_req  = mem_req_reg;
  assign mem_we   = mem_we_reg;
  assign mem_adr  = mem_adr_reg;
  assign mem_dout = mem_dout_reg;

endmodule

// File: tb/tb_lsu_16b.sv
// Directed bench for lsu_16b: bus beats and load results are checked against scoreboard queues.
`timescale 1ns/1ps
module tb_lsu_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lsu_adr = '0;
  logic [15:0] lsu_payload = '0;
  logic        sched_start = 1'b0;
  logic        sched_we = 1'b0;
  logic        sched_wide = 1'b0;
  logic        lsu_busy, lsu_done, rf_ld_we, mem_req, mem_we;
  logic [15:0] rf_ld, mem_adr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;
  logic        mem_rdy = 1'b0;

  always #5 clk = ~clk;

  lsu_16b dut (
    .clk(clk), .rst(rst), .lsu_adr(lsu_adr), .lsu_payload(lsu_payload),
    .sched_start(sched_start), .sched_we(sched_we), .sched_wide(sched_wide),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .rf_ld(rf_ld), .rf_ld_we(rf_ld_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_rdy(mem_rdy)
  );

  typedef struct packed {logic [15:0] adr; logic we; logic [7:0] dout;} beat_t;
  typedef struct packed {logic we; logic [15:0] data;} res_t;

  beat_t beat_q[$];
  res_t  res_q[$];
  beat_t mon_b;
  res_t  mon_r;
  int    checks = 0;
  int    errors = 0;
  logic [7:0] mem_model [0:65535];
  int    wait_cfg = 0;
  int    wait_cnt = 0;
  logic  hold_bus = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] second_adr(input logic [15:0] a);
`ifdef LSU_PAGE_WRAP_EN
    return {a[15:8], 8'(a[7:0] + 8'd1)};
`else
    return 16'(a + 16'd1);
`endif
  endfunction

  // Bus slave: answers wait_cfg cycles after a beat starts, unless hold_bus stalls it.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_rdy  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req && !hold_bus && wait_cnt >= wait_cfg) begin
      mem_rdy  = 1'b1;
      mem_din  = mem_model[mem_adr];
      wait_cnt = 0;
    end else begin
      mem_rdy = 1'b0;
      if (mem_req) wait_cnt++;
    end
  end

  // Monitor: compare completed bus beats and completions against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_rdy) begin
        checks++;
        assert (beat_q.size() != 0) else begin
          errors++;
          $error("FAIL beat_unexpected observed adr=%h expected no beat", mem_adr);
        end
        if (beat_q.size() != 0) begin
          mon_b = beat_q.pop_front();
          chk("beat_adr", 32'(mem_adr), 32'(mon_b.adr));
          chk("beat_we", 32'(mem_we), 32'(mon_b.we));
          if (mon_b.we) chk("beat_dout", 32'(mem_dout), 32'(mon_b.dout));
          if (mem_we) mem_model[mem_adr] = mem_dout;
        end
      end
      if (lsu_done) begin
        checks++;
        assert (res_q.size() != 0) else begin
          errors++;
          $error("FAIL done_unexpected observed done=1 expected done=0");
        end
        if (res_q.size() != 0) begin
          mon_r = res_q.pop_front();
          chk("rf_ld_we", 32'(rf_ld_we), 32'(!mon_r.we));
          if (!mon_r.we) chk("rf_ld", 32'(rf_ld), 32'(mon_r.data));
          $display("txn we=%0d rf_ld=%h rf_ld_we=%0d t=%0t", mon_r.we, rf_ld, rf_ld_we, $time);
        end
      end
    end
  end

  // Caller is at a negedge; the request is sampled at the following posedge.
  task automatic start_req(input logic we, input logic wide, input logic [15:0] adr, input logic [15:0] pay);
    logic [15:0] a2;
    res_t r;
    a2 = second_adr(adr);
    sched_start = 1'b1;
    sched_we    = we;
    sched_wide  = wide;
    lsu_adr     = adr;
    lsu_payload = pay;
    beat_q.push_back({adr, we, pay[7:0]});
    if (wide) beat_q.push_back({a2, we, pay[15:8]});
    r.we   = we;
    r.data = wide ? {mem_model[a2], mem_model[adr]} : {8'h00, mem_model[adr]};
    res_q.push_back(r);
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1) sched_start = 1'b0;
      if (lsu_done) begin
        cyc = i;
        break;
      end
    end
    chk(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    for (int i = 0; i < 65536; i++) mem_model[i] = 8'(i ^ (i >> 8) ^ 32'h5A);
    mem_model[16'h1234] = 8'hCD;
    mem_model[16'h1235] = 8'hAB;
    mem_model[16'h0300] = 8'hF0;
    mem_model[16'h0301] = 8'hEE;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_rf_ld", 32'(rf_ld), 32'd0);
    chk("rst_rf_ld_we", 32'(rf_ld_we), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Wide load, zero wait
    start_req(1'b0, 1'b1, 16'h1234, 16'h0000);
    wait_done("wide_load_latency", 3);
    chk("wide_load_data", 32'(rf_ld), 32'h0000ABCD);
    chk("wide_load_we", 32'(rf_ld_we), 32'd1);
    @(negedge clk);
    chk("rf_ld_hold", 32'(rf_ld), 32'h0000ABCD);
    chk("done_pulse_one_cycle", 32'(lsu_done), 32'd0);

    // Byte store with two wait states
    wait_cfg = 2;
    start_req(1'b1, 1'b0, 16'h0200, 16'h5A77);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) sched_start = 1'b0;
      chk("store_req_held", 32'(mem_req), 32'd1);
      chk("store_we_held", 32'(mem_we), 32'd1);
      chk("store_dout_held", 32'(mem_dout), 32'h77);
      chk("store_no_early_done", 32'(lsu_done), 32'd0);
    end
    @(negedge clk);
    chk("store_done_cycle4", 32'(lsu_done), 32'd1);
    chk("store_rf_ld_we", 32'(rf_ld_we), 32'd0);
    chk("store_mem_req_off", 32'(mem_req), 32'd0);
    chk("store_written", 32'(mem_model[16'h0200]), 32'h77);
    wait_cfg = 0;
    @(negedge clk);

    // Address wrap cases
    start_req(1'b0, 1'b1, 16'h12FF, 16'h0000);
    wait_done("wrap_12ff_latency", 3);
    @(negedge clk);
    start_req(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    wait_done("wrap_ffff_latency", 3);
    @(negedge clk);

    // Byte load, zero-extended
    start_req(1'b0, 1'b0, 16'h0300, 16'h0000);
    wait_done("byte_load_latency", 2);
    chk("byte_load_zext", 32'(rf_ld), 32'h000000F0);
    @(negedge clk);

    // Back-to-back with an ignored mid-transaction start
    start_req(1'b0, 1'b1, 16'h4000, 16'h0000);
    @(negedge clk);
    sched_start = 1'b0;
    @(negedge clk);
    chk("b2b_in_byte1", 32'(lsu_busy), 32'd1);
    sched_start = 1'b1;
    sched_we    = 1'b1;
    sched_wide  = 1'b0;
    lsu_adr     = 16'h5555;
    lsu_payload = 16'h1111;
    @(negedge clk);
    chk("b2b_first_done", 32'(lsu_done), 32'd1);
    start_req(1'b0, 1'b0, 16'h4100, 16'h0000);
    @(negedge clk);
    sched_start = 1'b0;
    chk("b2b_second_req", 32'(mem_req), 32'd1);
    chk("b2b_second_adr", 32'(mem_adr), 32'h4100);
    chk("b2b_second_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("b2b_second_done", 32'(lsu_done), 32'd1);
    @(negedge clk);

    // Reset asserted while stalled in the second byte
    start_req(1'b0, 1'b1, 16'h6000, 16'h0000);
    @(negedge clk);
    sched_start = 1'b0;
    hold_bus = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    chk("rst_mid_adr_before", 32'(mem_adr), 32'(second_adr(16'h6000)));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_async", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(lsu_busy), 32'd0);
    chk("rst_mid_adr", 32'(mem_adr), 32'd0);
    chk("rst_mid_rf_ld", 32'(rf_ld), 32'd0);
    beat_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b0;
    hold_bus = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_done) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 32'd0);

    chk("beat_queue_drained", 32'(beat_q.size()), 32'd0);
    chk("result_queue_drained", 32'(res_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
